// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite memory slave with independent write (AW/W/B) and read (AR/R) paths,
// byte-lane strobes and SLVERR for accesses at or beyond MEM_BYTES.
module axi_lite_mem_slave #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 64
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RVALID,
  input  logic                RREADY
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_HI = $clog2(MEM_BYTES);
  localparam int WORDS  = MEM_BYTES / STRB_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_COLLECT, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t wstate;
  rstate_t rstate;

  logic [DATA_W-1:0] mem [WORDS];

  logic              aw_have, w_have;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;

  logic aw_hs, w_hs, ar_hs;
  logic aw_ok, ar_ok;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign ar_hs = ARVALID && ARREADY;
  assign aw_ok = awaddr_q < ADDR_W'(MEM_BYTES);
  assign ar_ok = ARADDR < ADDR_W'(MEM_BYTES);

  // Write path owns the memory array, so its reset clear lives here too.
  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      wstate   <= W_COLLECT;
      AWREADY  <= 1'b0;
      WREADY   <= 1'b0;
      BVALID   <= 1'b0;
      BRESP    <= '0;
      aw_have  <= 1'b0;
      w_have   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      for (int unsigned i = 0; i < WORDS; i++) mem[i] <= '0;
    end else begin
      case (wstate)
        W_COLLECT: begin
          if (aw_have && w_have) begin
            if (aw_ok) begin
              for (int unsigned i = 0; i < STRB_W; i++)
                if (wstrb_q[i])
                  mem[awaddr_q[IDX_HI-1:LSB]][8*i +: 8] <= wdata_q[8*i +: 8];
            end
            BRESP   <= aw_ok ? RESP_OKAY : RESP_SLVERR;
            BVALID  <= 1'b1;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            aw_have <= 1'b0;
            w_have  <= 1'b0;
            wstate  <= W_RESP;
          end else begin
            if (aw_hs) begin
              awaddr_q <= AWADDR;
              aw_have  <= 1'b1;
            end
            if (w_hs) begin
              wdata_q <= WDATA;
              wstrb_q <= WSTRB;
              w_have  <= 1'b1;
            end
            // Ready stays low once a channel is captured; also raises it on the first edge after reset.
            AWREADY <= !(aw_have || aw_hs);
            WREADY  <= !(w_have || w_hs);
          end
        end
        W_RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            BRESP   <= '0;
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
            wstate  <= W_COLLECT;
          end
        end
        default: wstate <= W_COLLECT;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      rstate  <= R_IDLE;
      ARREADY <= 1'b0;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      RRESP   <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (ar_hs) begin
            RDATA   <= ar_ok ? mem[ARADDR[IDX_HI-1:LSB]] : '0;
            RRESP   <= ar_ok ? RESP_OKAY : RESP_SLVERR;
            RVALID  <= 1'b1;
            ARREADY <= 1'b0;
            rstate  <= R_DATA;
          end else begin
            ARREADY <= 1'b1;
          end
        end
        R_DATA: begin
          if (RREADY) begin
            RVALID  <= 1'b0;
            ARREADY <= 1'b1;
            rstate  <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// Scoreboard bench for axi_lite_mem_slave: stimulus pushes expected B/R responses,
// a negedge monitor pops and compares them as each response handshake is presented.
module tb_axi_lite_mem_slave;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;

  int tests = 0;
  int fails = 0;

  logic [1:0]  exp_b[$];
  logic [33:0] exp_r[$];

  axi_lite_mem_slave #(.DATA_W(32), .ADDR_W(32), .MEM_BYTES(64)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  // Monitor: compare each response at the negedge preceding its handshake edge.
  always @(negedge ACLK) begin
    if (ARESET && BVALID && BREADY) begin
      if (exp_b.size() == 0) chk("b_unexpected", 64'(BVALID), 64'd0);
      else chk("bresp", 64'(BRESP), 64'(exp_b.pop_front()));
    end
    if (ARESET && RVALID && RREADY) begin
      if (exp_r.size() == 0) chk("r_unexpected", 64'(RVALID), 64'd0);
      else chk("rresp_rdata", 64'({RRESP, RDATA}), 64'(exp_r.pop_front()));
    end
  end

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] resp);
    logic aw_f, w_f;
    int n = 0;
    exp_b.push_back(resp);
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
    while ((AWVALID || WVALID) && n < 50) begin
      @(negedge ACLK);
      aw_f = AWVALID && AWREADY;
      w_f  = WVALID && WREADY;
      @(posedge ACLK); #1;
      if (aw_f) AWVALID = 1'b0;
      if (w_f)  WVALID  = 1'b0;
      n++;
    end
    if (AWVALID || WVALID) begin
      timeout_fail("aw_w_accept");
      AWVALID = 1'b0; WVALID = 1'b0;
    end
  endtask

  task automatic axi_ar(input logic [31:0] a, input logic [1:0] resp, input logic [31:0] d);
    logic f;
    int n = 0;
    exp_r.push_back({resp, d});
    ARADDR = a; ARVALID = 1'b1;
    while (ARVALID && n < 50) begin
      @(negedge ACLK);
      f = ARVALID && ARREADY;
      @(posedge ACLK); #1;
      if (f) ARVALID = 1'b0;
      n++;
    end
    if (ARVALID) begin
      timeout_fail("ar_accept");
      ARVALID = 1'b0;
    end
  endtask

  task automatic wait_b();
    int n = 0;
    while (n < 50) begin
      @(negedge ACLK);
      if (BVALID && BREADY) break;
      n++;
    end
    if (n >= 50) timeout_fail("b_wait");
    @(posedge ACLK); #1;
  endtask

  task automatic wait_r();
    int n = 0;
    while (n < 50) begin
      @(negedge ACLK);
      if (RVALID && RREADY) break;
      n++;
    end
    if (n >= 50) timeout_fail("r_wait");
    @(posedge ACLK); #1;
  endtask

  task automatic axi_read(input logic [31:0] a, input logic [1:0] resp, input logic [31:0] d);
    axi_ar(a, resp, d);
    wait_r();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    ARESET = 1'b0;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    ARADDR = '0; ARVALID = 1'b0; BREADY = 1'b1; RREADY = 1'b1;

    repeat (3) @(posedge ACLK);
    #1;
    chk("reset_outputs", 64'({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA}), 64'd0);
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    chk("ready_after_release", 64'({AWREADY, WREADY, ARREADY}), 64'b111);

    // Test 1: AW+W same cycle, check response latency, then read back.
    exp_b.push_back(2'b00);
    AWADDR = 32'h04; WDATA = 32'hDEADBEEF; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("t1_bvalid_edge_n", 64'(BVALID), 64'd0);
    @(posedge ACLK); #1;
    chk("t1_bvalid_edge_n1", 64'(BVALID), 64'd1);
    wait_b();
    axi_read(32'h04, 2'b00, 32'hDEADBEEF);

    // Test 2: W three cycles ahead of AW, partial strobe merge.
    axi_write(32'h08, 32'hAABBCCDD, 4'hF, 2'b00);
    wait_b();
    exp_b.push_back(2'b00);
    WDATA = 32'h11223344; WSTRB = 4'b0101; WVALID = 1'b1;
    @(posedge ACLK); #1;
    WVALID = 1'b0;
    repeat (2) @(posedge ACLK);
    #1;
    chk("t2_wready_held_low", 64'({WREADY, AWREADY, BVALID}), 64'b010);
    AWADDR = 32'h08; AWVALID = 1'b1;
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    wait_b();
    axi_read(32'h08, 2'b00, 32'hAA22CC44);

    // Zero strobe leaves the word intact.
    axi_write(32'h08, 32'hFFFFFFFF, 4'h0, 2'b00);
    wait_b();
    axi_read(32'h08, 2'b00, 32'hAA22CC44);

    // Test 3: out-of-range write/read; word 0 (the alias of 0x40) stays zero.
    axi_write(32'h40, 32'hFFFFFFFF, 4'hF, 2'b10);
    wait_b();
    axi_read(32'h40, 2'b10, 32'h0);
    axi_read(32'h00, 2'b00, 32'h0);
    axi_read(32'h3C, 2'b00, 32'h0);

    // Test 4: backpressure on B and R holds responses stable.
    BREADY = 1'b0; RREADY = 1'b0;
    axi_write(32'h10, 32'h01020304, 4'hF, 2'b00);
    axi_ar(32'h04, 2'b00, 32'hDEADBEEF);
    n = 0;
    while (!(BVALID && RVALID) && n < 50) begin
      @(negedge ACLK);
      n++;
    end
    if (n >= 50) timeout_fail("t4_valids");
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("t4_b_stable", 64'({BVALID, BRESP}), 64'b100);
      chk("t4_r_stable", 64'({RVALID, RRESP, RDATA}), {29'd0, 3'b100, 32'hDEADBEEF});
      chk("t4_readies_low", 64'({AWREADY, WREADY, ARREADY}), 64'd0);
    end
    @(posedge ACLK); #1;
    BREADY = 1'b1; RREADY = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    chk("t4_drained", 64'({BVALID, RVALID, AWREADY, WREADY, ARREADY}), 64'b00111);
    axi_read(32'h10, 2'b00, 32'h01020304);

    // Test 5: read captured on the write-commit edge returns old data.
    exp_b.push_back(2'b00);
    exp_r.push_back({2'b00, 32'h0});
    AWADDR = 32'h0C; WDATA = 32'h5A5A5A5A; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    ARADDR = 32'h0C; ARVALID = 1'b1;
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    chk("t5_both_valid", 64'({BVALID, RVALID}), 64'b11);
    repeat (2) @(posedge ACLK);
    #1;
    axi_read(32'h0C, 2'b00, 32'h5A5A5A5A);

    // Test 6: reset with AW captured but W pending.
    AWADDR = 32'h14; AWVALID = 1'b1;
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    #2;
    ARESET = 1'b0;
    #1;
    chk("t6_outputs_in_reset", 64'({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA}), 64'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b1;
    @(posedge ACLK); #1;
    chk("t6_ready_after_release", 64'({AWREADY, WREADY, ARREADY}), 64'b111);
    WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WVALID = 1'b1;
    @(posedge ACLK); #1;
    WVALID = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("t6_no_bvalid", 64'(BVALID), 64'd0);
    end
    AWADDR = 32'h14; AWVALID = 1'b1;
    exp_b.push_back(2'b00);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    wait_b();
    axi_read(32'h04, 2'b00, 32'h0);
    axi_read(32'h0C, 2'b00, 32'h0);
    axi_read(32'h14, 2'b00, 32'hCAFEF00D);

    repeat (2) @(posedge ACLK);
    chk("queues_empty", 64'(exp_b.size() + exp_r.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
